// File: rtl/count_checker.sv
// ---------------------------------------------------------------------------
// count_checker
// Receive-side monitor for a free-running up-counter bus. It samples the
// counter value on each enabled cycle and locks onto the +1 (mod 2^WIDTH)
// sequence. Once locked, it flags every discontinuity with a one-cycle error
// pulse, a saturating error count and a capture of the offending value.
//
// Ports
//   clk       in   rising-edge clock, same domain as the monitored counter
//   clr       in   asynchronous active-high reset
//   en        in   sample strobe; q_in is checked only while en=1
//   q_in      in   counter value under test
//   err_clr   in   synchronous clear of err_count and last_bad
//   locked    out  1 while the FSM is in LOCKED
//   err       out  one-cycle pulse per detected discontinuity
//   err_count out  saturating count of discontinuities since reset/err_clr
//   last_bad  out  q_in value of the most recent discontinuity
//   state     out  FSM state for debug: 0 IDLE, 1 ACQ, 2 LOCKED
// ---------------------------------------------------------------------------
module count_checker #(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     last_bad,
  output logic [1:0]           state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  // The good-run counter only has to reach LOCK_CNT.
  localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [GOOD_W-1:0]    LOCK_TGT = GOOD_W'(LOCK_CNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0]     last_bad_q, last_bad_d;

  logic [WIDTH-1:0]     prev_inc_s;
  logic [GOOD_W-1:0]    good_inc_s;
  logic                 match_s;

  // Expected next value wraps naturally at WIDTH bits, so all-ones -> 0 matches.
  always_comb begin
    prev_inc_s = prev_q + WIDTH'(1);
    good_inc_s = good_q + GOOD_W'(1);
    match_s    = (q_in == prev_inc_s);
  end

  // FSM next state, sample history and good-run counter.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    if (en) begin
      prev_d = q_in;
    end else begin
      prev_d = prev_q;
    end
    case (state_q)
      S_IDLE: begin
        // First sample after reset only seeds prev.
        if (en) begin
          state_d = S_ACQ;
          good_d  = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_ACQ: begin
        // Mismatches while acquiring just restart the run; they are not errors.
        if (en && match_s) begin
          if (good_inc_s == LOCK_TGT) begin
            state_d = S_LOCKED;
            good_d  = '0;
          end else begin
            good_d  = good_inc_s;
          end
        end else if (en) begin
          good_d = '0;
        end else begin
          good_d = good_q;
        end
      end
      S_LOCKED: begin
        if (en && !match_s) begin
          err_d   = 1'b1;
          state_d = S_ACQ;
          good_d  = '0;
        end else begin
          state_d = S_LOCKED;
        end
      end
      default: begin
        // Unused encoding recovers to IDLE.
        state_d = S_IDLE;
        good_d  = '0;
      end
    endcase
    locked_d = (state_d == S_LOCKED);
  end

  // Error bookkeeping: a detected error takes priority over err_clr.
  always_comb begin
    err_count_d = err_count_q;
    last_bad_d  = last_bad_q;
    if (err_d) begin
      last_bad_d = q_in;
      if (err_clr) begin
        err_count_d = ERR_ONE;
      end else if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + ERR_ONE;
      end else begin
        err_count_d = err_count_q;
      end
    end else if (err_clr) begin
      err_count_d = '0;
      last_bad_d  = '0;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers, cleared asynchronously by clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      prev_q      <= '0;
      good_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      last_bad_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      last_bad_q  <= last_bad_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign last_bad  = last_bad_q;
  assign state     = state_q;

endmodule

// File: tb/tb_count_checker.sv
module tb_count_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic [3:0] q_in = 4'd0;
  logic       err_clr = 1'b0;
  logic       locked;
  logic       err;
  logic [1:0] err_count;
  logic [3:0] last_bad;
  logic [1:0] state;

  // ERR_CNT_W=2 so the saturation corner is reachable with a handful of errors.
  count_checker #(.WIDTH(4), .LOCK_CNT(4), .ERR_CNT_W(2)) dut (
    .clk(clk), .clr(clr), .en(en), .q_in(q_in), .err_clr(err_clr),
    .locked(locked), .err(err), .err_count(err_count),
    .last_bad(last_bad), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       locked;
    logic       err;
    logic [1:0] cnt;
    logic [3:0] lb;
    logic [1:0] st;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic [3:0] q;
    logic       ec;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t mk(input logic l, input logic e, input logic [1:0] c,
                              input logic [3:0] lb, input logic [1:0] st);
    exp_t x;
    x.locked = l; x.err = e; x.cnt = c; x.lb = lb; x.st = st;
    return x;
  endfunction

  function automatic vec_t mv(input logic e, input logic [3:0] q, input logic ec, input exp_t x);
    vec_t v;
    v.en = e; v.q = q; v.ec = ec; v.exp = x;
    return v;
  endfunction

  task automatic chk(input string name);
    exp_t x;
    exp_t act;
    x = sb.pop_front();
    act = '{locked, err, err_count, last_bad, state};
    n_tests++;
    if (act !== x) begin
      n_fail++;
      $display("FAIL %s: got locked=%b err=%b cnt=%0d last_bad=%0d state=%0d, want locked=%b err=%b cnt=%0d last_bad=%0d state=%0d",
               name, act.locked, act.err, act.cnt, act.lb, act.st,
               x.locked, x.err, x.cnt, x.lb, x.st);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] q, input logic ec,
                      input exp_t x, input string name);
    @(negedge clk);
    en = e; q_in = q; err_clr = ec;
    sb.push_back(x);
    @(posedge clk);
    #1;
    chk(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[$];
    logic [3:0] cur;
    logic [3:0] bad;
    logic [1:0] c;

    // Reset held: random inputs must not disturb anything.
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           mk(1'b0, 1'b0, 2'd0, 4'd0, 2'd0), "reset");
    @(negedge clk);
    clr = 1'b0;

    // Lock: seed, then LOCK_CNT matches.
    tbl.push_back(mv(1'b1, 4'd0, 1'b0, mk(1'b0, 1'b0, 2'd0, 4'd0, 2'd1)));
    tbl.push_back(mv(1'b1, 4'd1, 1'b0, mk(1'b0, 1'b0, 2'd0, 4'd0, 2'd1)));
    tbl.push_back(mv(1'b1, 4'd2, 1'b0, mk(1'b0, 1'b0, 2'd0, 4'd0, 2'd1)));
    tbl.push_back(mv(1'b1, 4'd3, 1'b0, mk(1'b0, 1'b0, 2'd0, 4'd0, 2'd1)));
    tbl.push_back(mv(1'b1, 4'd4, 1'b0, mk(1'b1, 1'b0, 2'd0, 4'd0, 2'd2)));
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].en, tbl[i].q, tbl[i].ec, tbl[i].exp, "lock");

    // Wrap through 15 -> 0 while locked, ending at 6.
    cur = 4'd4;
    for (int i = 0; i < 18; i++) begin
      cur = cur + 4'd1;
      step(1'b1, cur, 1'b0, mk(1'b1, 1'b0, 2'd0, 4'd0, 2'd2), "wrap");
    end

    // Skip 6 -> 8, relock on 9..12 with en=0 gaps carrying junk values.
    tbl.delete();
    tbl.push_back(mv(1'b1, 4'd8,  1'b0, mk(1'b0, 1'b1, 2'd1, 4'd8, 2'd1)));
    tbl.push_back(mv(1'b1, 4'd9,  1'b0, mk(1'b0, 1'b0, 2'd1, 4'd8, 2'd1)));
    tbl.push_back(mv(1'b0, 4'd3,  1'b0, mk(1'b0, 1'b0, 2'd1, 4'd8, 2'd1)));
    tbl.push_back(mv(1'b1, 4'd10, 1'b0, mk(1'b0, 1'b0, 2'd1, 4'd8, 2'd1)));
    tbl.push_back(mv(1'b0, 4'd7,  1'b0, mk(1'b0, 1'b0, 2'd1, 4'd8, 2'd1)));
    tbl.push_back(mv(1'b1, 4'd11, 1'b0, mk(1'b0, 1'b0, 2'd1, 4'd8, 2'd1)));
    tbl.push_back(mv(1'b1, 4'd12, 1'b0, mk(1'b1, 1'b0, 2'd1, 4'd8, 2'd2)));
    tbl.push_back(mv(1'b0, 4'd0,  1'b0, mk(1'b1, 1'b0, 2'd1, 4'd8, 2'd2)));
    tbl.push_back(mv(1'b1, 4'd13, 1'b0, mk(1'b1, 1'b0, 2'd1, 4'd8, 2'd2)));
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].en, tbl[i].q, tbl[i].ec, tbl[i].exp, "skip");
    cur = 4'd13;

    // err_clr alone: count and capture cleared, FSM untouched.
    step(1'b0, 4'd0, 1'b1, mk(1'b1, 1'b0, 2'd0, 4'd0, 2'd2), "err_clr");

    // Five discontinuities, each followed by a relock; count saturates at 3.
    for (int k = 0; k < 5; k++) begin
      bad = cur + 4'd2;
      c = (k >= 2) ? 2'd3 : 2'(k + 1);
      step(1'b1, bad, 1'b0, mk(1'b0, 1'b1, c, bad, 2'd1), "sat_err");
      cur = bad;
      for (int j = 0; j < 4; j++) begin
        cur = cur + 4'd1;
        step(1'b1, cur, 1'b0,
             mk((j == 3), 1'b0, c, bad, (j == 3) ? 2'd2 : 2'd1), "sat_relock");
      end
    end

    // Error coinciding with err_clr: error wins, count restarts at 1.
    bad = cur + 4'd3;
    step(1'b1, bad, 1'b1, mk(1'b0, 1'b1, 2'd1, bad, 2'd1), "clr_vs_err");
    cur = bad;
    // Mismatch during acquisition is not an error.
    cur = cur + 4'd5;
    step(1'b1, cur, 1'b0, mk(1'b0, 1'b0, 2'd1, bad, 2'd1), "acq_mismatch");
    for (int j = 0; j < 4; j++) begin
      cur = cur + 4'd1;
      step(1'b1, cur, 1'b0,
           mk((j == 3), 1'b0, 2'd1, bad, (j == 3) ? 2'd2 : 2'd1), "relock");
    end

    // Async clr between edges while locked: immediate reset, no err pulse.
    @(negedge clk);
    en = 1'b0;
    #2 clr = 1'b1;
    #1;
    sb.push_back(mk(1'b0, 1'b0, 2'd0, 4'd0, 2'd0));
    chk("async_clr");
    #1 clr = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cur = cur + 4'd1;
      step(1'b1, cur, 1'b0,
           mk((j == 4), 1'b0, 2'd0, 4'd0, (j == 4) ? 2'd2 : 2'd1), "post_clr");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
